// File: rtl/noc_weighted_rr_arbiter_pkg.sv
// Shared types and defaults for the NoC weighted round-robin output arbiter.
// Contents: default requester count and weight width, the index type and
// the per-requester weight array type.
package noc_weighted_rr_arbiter_pkg;

  localparam int unsigned NOC_RR_REQUESTS = 4;
  localparam int unsigned NOC_RR_WEIGHT_W = 4;
  localparam int unsigned NOC_RR_IDX_W    = $clog2(NOC_RR_REQUESTS);

  typedef logic [NOC_RR_IDX_W-1:0] noc_rr_idx_t;
  typedef logic [NOC_RR_REQUESTS-1:0][NOC_RR_WEIGHT_W-1:0] noc_rr_weight_arr_t;

endpackage

// File: rtl/noc_weighted_rr_arbiter_if.sv
// Request/grant bundle between the input VCs and the output-port arbiter.
// Signals:
//   request, urgent, free : per-requester strobes from the input VCs
//   weight                : per-requester consecutive-win budget (quasi-static)
//   o_grant, o_grant_idx,
//   o_grant_valid         : one-hot grant, its binary index, and |o_grant
// Modports: master = requester side, slave = arbiter side.
interface noc_weighted_rr_arbiter_if
  import noc_weighted_rr_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTS = NOC_RR_REQUESTS,
  parameter int unsigned WEIGHT_W = NOC_RR_WEIGHT_W
);

  localparam int unsigned IDX_W = $clog2(REQUESTS);

  logic [REQUESTS-1:0]               request;
  logic [REQUESTS-1:0]               urgent;
  logic [REQUESTS-1:0][WEIGHT_W-1:0] weight;
  logic [REQUESTS-1:0]               free;
  logic [REQUESTS-1:0]               o_grant;
  logic [IDX_W-1:0]                  o_grant_idx;
  logic                              o_grant_valid;

  modport master (
    output request, urgent, weight, free,
    input  o_grant, o_grant_idx, o_grant_valid
  );

  modport slave (
    input  request, urgent, weight, free,
    output o_grant, o_grant_idx, o_grant_valid
  );

endinterface

// File: rtl/noc_weighted_rr_arbiter_pick.sv
// noc_rr_pick: circular find-first-set over a request vector.
// Ports:
//   vector : candidate bits
//   start  : first position examined; scan wraps and ends at start-1
//   found  : any bit of vector set
//   onehot : one-hot of the first set bit found
//   idx    : binary index of that bit (0 when nothing is found)
module noc_rr_pick #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vector,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  // Rotate through positions start, start+1, ... and keep the first hit.
  always_comb begin : scan
    logic [IDX_W-1:0] pos;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    pos    = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      pos = IDX_W'((32'(start) + k) % WIDTH);
      if (!found && vector[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    onehot[idx] = found;
  end

endmodule

// File: rtl/noc_weighted_rr_arbiter.sv
// Router output-port arbiter: weighted round-robin with an urgent class and
// packet hold until the owner signals free.
// Ports:
//   noc_clk   : clock
//   noc_rst_n : synchronous active-low reset
//   bus       : request/urgent/weight/free in, one-hot grant + index out
//               (grant outputs are combinational, zero-latency)
module noc_weighted_rr_arbiter
  import noc_weighted_rr_arbiter_pkg::*;
#(
  parameter int unsigned REQUESTS    = NOC_RR_REQUESTS,
  parameter int unsigned WEIGHT_W    = NOC_RR_WEIGHT_W,
  parameter int unsigned KEEP_RESULT = 1,
  parameter int unsigned INITIAL_PTR = REQUESTS - 1
) (
  input logic                     noc_clk,
  input logic                     noc_rst_n,
  noc_weighted_rr_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(REQUESTS);

  logic [REQUESTS-1:0] urg_req;
  logic [REQUESTS-1:0] cand;
  logic [REQUESTS-1:0] pick_onehot;
  logic [REQUESTS-1:0] grant_c;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    start;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    grant_idx_c;
  logic [WEIGHT_W-1:0] credit;
  logic [WEIGHT_W-1:0] win_weight;
  logic                pick_found;
  logic                stay;
  logic                grab;
  logic                busy;
  logic                busy_next;

  // Class mask: any urgent request hides every normal one.
  always_comb begin
    urg_req = bus.request & bus.urgent;
    cand    = (urg_req != '0) ? urg_req : bus.request;
    start   = (ptr == IDX_W'(REQUESTS - 1)) ? '0 : ptr + IDX_W'(1);
  end

  noc_rr_pick #(
    .WIDTH (REQUESTS)
  ) u_pick (
    .vector (cand),
    .start  (start),
    .found  (pick_found),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  // Winner: stay on ptr while it still has budget, else next in rotation.
  always_comb begin
    stay       = cand[ptr] && (credit != '0);
    winner     = stay ? ptr : pick_idx;
    grab       = pick_found && !busy;
    win_weight = bus.weight[winner];
  end

  // Output mux: fresh winner on a grab, held owner while busy, else idle.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    if (grab) begin
      grant_idx_c = winner;
      grant_c     = stay ? (REQUESTS'(1) << ptr) : pick_onehot;
    end else if (busy) begin
      grant_idx_c  = ptr;
      grant_c[ptr] = 1'b1;
    end
  end

  assign bus.o_grant       = grant_c;
  assign bus.o_grant_idx   = grant_idx_c;
  assign bus.o_grant_valid = |grant_c;

  // Pointer and budget; a zero weight behaves as one (budget of zero extra wins).
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      ptr    <= IDX_W'(INITIAL_PTR);
      credit <= '0;
    end else if (grab) begin
      if (winner == ptr) begin
        if (credit != '0) credit <= credit - WEIGHT_W'(1);
      end else begin
        ptr    <= winner;
        credit <= (win_weight == '0) ? '0 : win_weight - WEIGHT_W'(1);
      end
    end
  end

  // Packet hold: release beats a new grab in the same cycle.
  generate
    if (KEEP_RESULT != 0) begin : g_hold
      always_comb begin
        busy_next = busy;
        if ((grant_c & bus.free) != '0) busy_next = 1'b0;
        else if (grab)                  busy_next = 1'b1;
      end

      always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) busy <= 1'b0;
        else            busy <= busy_next;
      end
    end else begin : g_no_hold
      assign busy_next = 1'b0;
      assign busy      = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_noc_weighted_rr_arbiter.sv
// Bench for noc_weighted_rr_arbiter: one instance with packet hold, one
// re-arbitrating every cycle, both fed the same directed stimulus.
module tb_noc_weighted_rr_arbiter;
  import noc_weighted_rr_arbiter_pkg::*;

  localparam int unsigned N = NOC_RR_REQUESTS;
  localparam int SEQ_B [11] = '{3, 3, 3, 0, 3, 3, 3, 0, 3, 3, 3};
  localparam int SEQ_C [6]  = '{2, 2, 2, 0, 1, 2};

  logic               noc_clk;
  logic               noc_rst_n;
  logic [N-1:0]       req;
  logic [N-1:0]       urg;
  logic [N-1:0]       free;
  noc_rr_weight_arr_t wt;

  int n_cmp;
  int n_err;

  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;

  noc_weighted_rr_arbiter_if #(.REQUESTS(N), .WEIGHT_W(NOC_RR_WEIGHT_W)) if1 ();
  noc_weighted_rr_arbiter_if #(.REQUESTS(N), .WEIGHT_W(NOC_RR_WEIGHT_W)) if0 ();

  assign if1.request = req;
  assign if1.urgent  = urg;
  assign if1.weight  = wt;
  assign if1.free    = free;
  assign if0.request = req;
  assign if0.urgent  = urg;
  assign if0.weight  = wt;
  assign if0.free    = free;

  noc_weighted_rr_arbiter #(
    .REQUESTS(N), .WEIGHT_W(NOC_RR_WEIGHT_W), .KEEP_RESULT(1)
  ) dut_keep (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .bus(if1)
  );

  noc_weighted_rr_arbiter #(
    .REQUESTS(N), .WEIGHT_W(NOC_RR_WEIGHT_W), .KEEP_RESULT(0)
  ) dut_free (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .bus(if0)
  );

  // ---------------- behavioural model (k=0: hold, k=1: no hold) -----------
  int m_ptr  [2];
  int m_cred [2];
  bit m_busy [2];
  bit m_live;

  function automatic logic [N-1:0] model_cand();
    logic [N-1:0] c;
    c = req & urg;
    if (c == '0) c = req;
    return c;
  endfunction

  // Serve order: current owner if it has budget, else ptr+1, ptr+2, ... ptr.
  function automatic int model_winner(input int k);
    logic [N-1:0] c;
    int w;
    int cand_i;
    c = model_cand();
    w = -1;
    if (c[m_ptr[k]] == 1'b1 && m_cred[k] > 0) w = m_ptr[k];
    for (int s = 1; s <= int'(N); s++) begin
      cand_i = (m_ptr[k] + s) % int'(N);
      if (w < 0 && c[cand_i] == 1'b1) w = cand_i;
    end
    return w;
  endfunction

  task automatic check_out(input string nm, input int k, input logic [N-1:0] eg,
                           input int ei);
    logic [N-1:0] ag;
    noc_rr_idx_t  ai;
    logic         av;
    ag = (k == 0) ? if1.o_grant       : if0.o_grant;
    ai = (k == 0) ? if1.o_grant_idx   : if0.o_grant_idx;
    av = (k == 0) ? if1.o_grant_valid : if0.o_grant_valid;
    n_cmp++;
    if (ag !== eg || ai !== noc_rr_idx_t'(ei) || av !== (eg != '0)) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t: grant=%b idx=%0d valid=%b, required grant=%b idx=%0d valid=%b",
               nm, k, $time, ag, ai, av, eg, ei, (eg != '0));
    end
  endtask

  // Compare every cycle against the model, then advance it to the next edge.
  always @(negedge noc_clk) begin : compare
    int w;
    int ei;
    int eff;
    bit grab;
    logic [N-1:0] eg;
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        w    = model_winner(k);
        grab = (model_cand() != '0) && !m_busy[k];
        ei   = grab ? w : (m_busy[k] ? m_ptr[k] : 0);
        eg   = (grab || m_busy[k]) ? (N'(1) << ei) : '0;
        check_out("model", k, eg, ei);
        if (grab) begin
          if (w == m_ptr[k]) begin
            if (m_cred[k] > 0) m_cred[k] = m_cred[k] - 1;
          end else begin
            eff       = (wt[w] == '0) ? 1 : int'(wt[w]);
            m_ptr[k]  = w;
            m_cred[k] = eff - 1;
          end
        end
        if (k == 0) begin
          if ((eg & free) != '0) m_busy[k] = 1'b0;
          else if (grab)         m_busy[k] = 1'b1;
        end
      end
    end
    if (!noc_rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ptr[k]  = int'(N) - 1;
        m_cred[k] = 0;
        m_busy[k] = 1'b0;
      end
      m_live = 1'b1;
    end
  end

  // ---------------- directed stimulus with literal expectations -----------
  task automatic nxt();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic set_w(input int v);
    for (int i = 0; i < int'(N); i++) wt[i] = NOC_RR_WEIGHT_W'(v);
  endtask

  task automatic do_reset();
    noc_rst_n = 1'b0;
    req  = '0;
    urg  = '0;
    free = '0;
    nxt();
    nxt();
    noc_rst_n = 1'b1;
  endtask

  task automatic lit(input string nm, input int k, input int eidx, input bit evalid);
    check_out(nm, k, evalid ? (N'(1) << eidx) : N'(0), evalid ? eidx : 0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    m_live    = 1'b0;
    noc_rst_n = 1'b0;
    req       = '0;
    urg       = '0;
    free      = '0;
    set_w(1);

    // Reset state, then plain rotation with free one cycle after each grant.
    do_reset();
    #2;
    lit("reset_idle_hold", 0, 0, 1'b0);
    lit("reset_idle_nohold", 1, 0, 1'b0);
    nxt();
    req = '1;
    for (int j = 0; j < 5; j++) begin
      free = '0;
      #2;
      lit("rr_grant", 0, j % 4, 1'b1);
      nxt();
      free = N'(1) << (j % 4);
      #2;
      lit("rr_hold", 0, j % 4, 1'b1);
      nxt();
    end

    // Weighted budget: idx3 weight 3, free every cycle.
    set_w(1);
    wt[3] = NOC_RR_WEIGHT_W'(3);
    do_reset();
    free = '1;
    for (int j = 0; j < 11; j++) begin
      req = (j < 3) ? 4'b1000 : 4'b1001;
      #2;
      lit("weight_hold", 0, SEQ_B[j], 1'b1);
      lit("weight_nohold", 1, SEQ_B[j], 1'b1);
      nxt();
    end

    // Urgent class beats normal; rotation resumes from ptr=2 when cleared.
    set_w(1);
    do_reset();
    free = '1;
    req  = 4'b0111;
    for (int j = 0; j < 6; j++) begin
      urg = (j < 3) ? 4'b0100 : 4'b0000;
      #2;
      lit("urgent_class", 0, SEQ_C[j], 1'b1);
      nxt();
    end

    // Packet hold ignores new (urgent) requests and foreign free bits.
    do_reset();
    req = 4'b0010;
    #2;
    lit("hold_first", 0, 1, 1'b1);
    nxt();
    req = '1;
    urg = '1;
    for (int j = 0; j < 5; j++) begin
      free = (j == 2) ? 4'b1101 : 4'b0000;
      #2;
      lit("hold_busy", 0, 1, 1'b1);
      nxt();
    end
    free = 4'b0010;
    #2;
    lit("hold_release", 0, 1, 1'b1);
    nxt();
    free = '0;
    #2;
    lit("back_to_back", 0, 2, 1'b1);
    nxt();

    // No hold: alternate every cycle regardless of free.
    do_reset();
    req = 4'b0101;
    for (int j = 0; j < 6; j++) begin
      free = (j % 2 == 1) ? 4'b0101 : 4'b0000;
      #2;
      lit("nohold_alt", 1, (j % 2 == 1) ? 2 : 0, 1'b1);
      nxt();
    end

    // Reset in the middle of a held packet.
    do_reset();
    req = 4'b0100;
    #2;
    lit("pre_reset_grab", 0, 2, 1'b1);
    nxt();
    #2;
    lit("pre_reset_hold", 0, 2, 1'b1);
    noc_rst_n = 1'b0;
    req       = '0;
    nxt();
    noc_rst_n = 1'b1;
    #2;
    lit("post_reset_idle", 0, 0, 1'b0);
    nxt();
    req = '1;
    #2;
    lit("post_reset_first", 0, 0, 1'b1);
    nxt();
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
